// File: rtl/encoder_2nrm.sv
// encoder_2nrm
// Converts a 16-bit unsigned word into its 2NRM-RRNS residue set over the
// moduli {257, 256, 61, 59, 55, 53}. Each residue is formed combinationally by
// constant-modulus folding, and the packed result is registered on a start
// request (latency 1, done pulses with the update).
//
// Handshake: start is a fire-and-forget request with no ready. Every rising
// edge that sees start=1 samples data_in, registers its residues and drives
// done=1 for the following cycle. There is no back-pressure and no busy state.
//
// Packing of residues_out (MSB to LSB):
//   [63:41] zero, [40:32] r257, [31:24] r256, [23:18] r61,
//   [17:12] r59,  [11:6]  r55,  [5:0]   r53
module encoder_2nrm (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] data_in,
    output logic [63:0] residues_out,
    output logic        done
);

    // ------------------------------------------------------------------
    // Modulus 257: 2^8 == -1 (mod 257), so x = hi*256 + lo == lo - hi.
    // Offsetting by 257 keeps the difference positive (2..512); a single
    // conditional subtract then lands in 0..256.
    // ------------------------------------------------------------------
    function automatic logic [8:0] mod257(input logic [15:0] x);
        logic [9:0] t;
        logic [9:0] t_sub;
        t     = 10'(x[7:0]) + 10'd257 - 10'(x[15:8]);
        t_sub = t - 10'd257;
        mod257 = (t >= 10'd257) ? t_sub[8:0] : t[8:0];
    endfunction

    // ------------------------------------------------------------------
    // Six-bit moduli (53..61). Three folding stages on a 64 radix:
    //   stage 1: x = c2*4096 + c1*64 + c0 -> c0 + c1*w64 + c2*w4096 (<= 1020)
    //   stage 2: s1 = h*64 + l             -> l + h*w64             (<= 228)
    //   stage 3: s2 = h*64 + l             -> l + h*w64             (<= 96)
    // After stage 3 the value is below 2m for every modulus in the set, so
    // one conditional subtract completes the reduction. w64 = 64 mod m and
    // w4096 = 4096 mod m are constants at every call site.
    // ------------------------------------------------------------------
    function automatic logic [5:0] fold6(
        input logic [15:0] x,
        input logic [6:0]  m,
        input logic [4:0]  w64,
        input logic [4:0]  w4096
    );
        logic [9:0] s1;
        logic [7:0] s2;
        logic [6:0] s3;
        logic [6:0] s3_sub;
        s1 = 10'(x[5:0])
           + 10'(x[11:6])  * 10'(w64)
           + 10'(x[15:12]) * 10'(w4096);
        s2 = 8'(s1[5:0]) + 8'(s1[9:6]) * 8'(w64);
        s3 = 7'(s2[5:0]) + 7'(s2[7:6]) * 7'(w64);
        s3_sub = s3 - m;
        fold6 = (s3 >= m) ? s3_sub[5:0] : s3[5:0];
    endfunction

    // Residue datapath, purely combinational from data_in
    logic [8:0] r257;
    logic [7:0] r256;
    logic [5:0] r61;
    logic [5:0] r59;
    logic [5:0] r55;
    logic [5:0] r53;
    logic [63:0] packed_res;

    // Per-modulus reductions with their folding weights (64 mod m, 4096 mod m)
    always_comb begin
        r257 = mod257(data_in);
        r256 = data_in[7:0];
        r61  = fold6(data_in, 7'd61, 5'd3,  5'd9);
        r59  = fold6(data_in, 7'd59, 5'd5,  5'd25);
        r55  = fold6(data_in, 7'd55, 5'd9,  5'd26);
        r53  = fold6(data_in, 7'd53, 5'd11, 5'd15);
    end

    // Assemble the output word; the unused top field is forced to zero
    always_comb begin
        packed_res = {23'd0, r257, r256, r61, r59, r55, r53};
    end

    // Output stage: capture on start, hold otherwise; done follows start
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            residues_out <= 64'h0;
            done         <= 1'b0;
        end else begin
            if (start) begin
                residues_out <= packed_res;
            end
            done <= start;
        end
    end

endmodule

// File: tb/tb_encoder_2nrm.sv
// Testbench for encoder_2nrm: directed vectors, reset behaviour, hold,
// back-to-back requests, randomized traffic and an exhaustive 16-bit sweep,
// all checked against an arithmetic reference built on the % operator.
module tb_encoder_2nrm;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] data_in;
    logic [63:0] residues_out;
    logic        done;

    int checks;
    int failures;

    encoder_2nrm dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .data_in      (data_in),
        .residues_out (residues_out),
        .done         (done)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: residues by plain modulo, packed into their fields
    function automatic logic [63:0] ref_pack(input int unsigned d);
        logic [63:0] r;
        r = 64'h0;
        r[40:32] = 9'(d % 257);
        r[31:24] = 8'(d % 256);
        r[23:18] = 6'(d % 61);
        r[17:12] = 6'(d % 59);
        r[11:6]  = 6'(d % 55);
        r[5:0]   = 6'(d % 53);
        return r;
    endfunction

    // One-cycle encode request: drive on negedge, observe at next negedge
    task automatic encode_once(input logic [15:0] d);
        @(negedge clk);
        start   = 1'b1;
        data_in = d;
        @(negedge clk);
        start   = 1'b0;
    endtask

    task automatic test_reset();
        rst_n   = 1'b0;
        start   = 1'b0;
        data_in = 16'h0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            start   = 1'(i & 1);
            data_in = 16'($urandom_range(0, 65535));
            #2;
            checks++;
            if (residues_out !== 64'h0 || done !== 1'b0) begin
                failures++;
                $display("FAIL reset_hold: residues=%h done=%b expected 0/0", residues_out, done);
            end
        end
        @(negedge clk);
        start = 1'b0;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            data_in = 16'($urandom_range(0, 65535));
            checks++;
            if (residues_out !== 64'h0 || done !== 1'b0) begin
                failures++;
                $display("FAIL reset_release: residues=%h done=%b expected 0/0", residues_out, done);
            end
        end
    endtask

    task automatic test_zero();
        encode_once(16'd0);
        checks++;
        if (residues_out !== 64'h0 || done !== 1'b1) begin
            failures++;
            $display("FAIL zero_value: residues=%h done=%b expected 0/1", residues_out, done);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0) begin
            failures++;
            $display("FAIL zero_done_pulse: done=%b expected 0", done);
        end
    endtask

    task automatic test_vectors();
        logic [15:0] vals [4];
        logic [63:0] exps [4];
        vals[0] = 16'd65535; exps[0] = 64'h00000000FF56D79B;
        vals[1] = 16'd256;   exps[1] = 64'h000001000031492C;
        vals[2] = 16'd257;   exps[2] = 64'h000000000135596D;
        vals[3] = 16'd61;    exps[3] = 64'h0000003D3D002188;
        for (int i = 0; i < 4; i++) begin
            encode_once(vals[i]);
            checks++;
            if (residues_out !== exps[i] || done !== 1'b1) begin
                failures++;
                $display("FAIL vector_%0d: residues=%h done=%b expected %h/1",
                         vals[i], residues_out, done, exps[i]);
            end
        end
    endtask

    task automatic test_hold();
        logic [63:0] exp_v;
        encode_once(16'd12345);
        exp_v = ref_pack(12345);
        for (int i = 0; i < 5; i++) begin
            data_in = 16'($urandom_range(0, 65535));
            @(negedge clk);
            checks++;
            if (residues_out !== exp_v || done !== 1'b0) begin
                failures++;
                $display("FAIL hold: residues=%h done=%b expected %h/0", residues_out, done, exp_v);
            end
        end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        start   = 1'b1;
        data_in = 16'd12345;
        @(negedge clk);
        checks++;
        if (residues_out !== ref_pack(12345) || done !== 1'b1) begin
            failures++;
            $display("FAIL b2b_first: residues=%h done=%b expected %h/1",
                     residues_out, done, ref_pack(12345));
        end
        data_in = 16'd54321;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (residues_out !== ref_pack(54321) || done !== 1'b1) begin
            failures++;
            $display("FAIL b2b_second: residues=%h done=%b expected %h/1",
                     residues_out, done, ref_pack(54321));
        end
        @(negedge clk);
        checks++;
        if (residues_out !== ref_pack(54321) || done !== 1'b0) begin
            failures++;
            $display("FAIL b2b_after: residues=%h done=%b expected %h/0",
                     residues_out, done, ref_pack(54321));
        end
    endtask

    // Random start/data traffic tracked by a last-captured-value model
    task automatic test_random();
        logic [63:0] exp_q[$];
        logic [63:0] exp_res;
        logic        exp_done;
        exp_res  = residues_out;
        exp_done = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            start   = 1'($urandom_range(0, 1));
            data_in = 16'($urandom);
            if (start) exp_q.push_back(ref_pack(int'(data_in)));
            exp_done = start;
            @(posedge clk);
            #1;
            if (exp_done) exp_res = exp_q.pop_front();
            checks++;
            if (residues_out !== exp_res || done !== exp_done) begin
                failures++;
                $display("FAIL random_%0d: residues=%h done=%b expected %h/%b",
                         i, residues_out, done, exp_res, exp_done);
            end
        end
        @(negedge clk);
        start = 1'b0;
    endtask

    // Mid-operation reset discards the captured result at once
    task automatic test_async_reset();
        encode_once(16'd40000);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (residues_out !== 64'h0 || done !== 1'b0) begin
            failures++;
            $display("FAIL async_reset: residues=%h done=%b expected 0/0", residues_out, done);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Every input value, one request per cycle
    task automatic test_exhaustive();
        logic [63:0] exp_v;
        @(negedge clk);
        start   = 1'b1;
        data_in = 16'd0;
        for (int i = 0; i < 65536; i++) begin
            @(negedge clk);
            exp_v = ref_pack(i);
            checks++;
            if (residues_out !== exp_v || done !== 1'b1 || residues_out[63:41] !== 23'd0) begin
                failures++;
                $display("FAIL exhaustive_%0d: residues=%h done=%b expected %h/1",
                         i, residues_out, done, exp_v);
            end
            if (i < 65535) data_in = 16'(i + 1);
            else start = 1'b0;
        end
        @(negedge clk);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        start    = 1'b0;
        data_in  = 16'h0;
        test_reset();
        test_zero();
        test_vectors();
        test_hold();
        test_back_to_back();
        test_random();
        test_async_reset();
        test_exhaustive();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
